// File: rtl/alu_issue_ctl.sv
// Issue/writeback controller that feeds a combinational ALU from a small register file.
// Optional immediate operand B is enabled by defining ALU_CTL_IMM_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ready for an instruction; operands latched on accept
// S_EXEC   | ALU evaluates; flags and writeback captured at end of cycle
// S_RETIRE | done pulse; back to idle on next edge
module alu_issue_ctl #(
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [3:0]        op,
  input  logic [REG_AW-1:0] ra,
  input  logic [REG_AW-1:0] rb,
`ifdef ALU_CTL_IMM_EN
  input  logic              imm_sel,
  input  logic [15:0]       imm,
`endif
  output logic [3:0]        alux,
  output logic [15:0]       arga,
  output logic [15:0]       argb,
  input  logic [15:0]       result,
  input  logic              sign,
  input  logic              carry,
  input  logic              zero,
  input  logic              parity,
  output logic [3:0]        flags,
  output logic              done,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [15:0]       rd_data
);

  localparam logic [3:0] OP_CMP = 4'b1110;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RETIRE} state_t;

  state_t            state;
  logic [REG_AW-1:0] dst;
  logic [15:0]       regs [NREGS];
  logic [15:0]       opb;

`ifdef ALU_CTL_IMM_EN
  assign opb = imm_sel ? imm : regs[rb];
`else
  assign opb = regs[rb];
`endif

  assign rd_data = regs[rd_addr];

  // Writeback is assigned after the external write so it wins on a shared target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      instr_ready <= 1'b1;
      done        <= 1'b0;
      alux        <= '0;
      arga        <= '0;
      argb        <= '0;
      flags       <= '0;
      dst         <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            alux        <= op;
            arga        <= regs[ra];
            argb        <= opb;
            dst         <= ra;
            instr_ready <= 1'b0;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          flags <= {sign, carry, zero, parity};
          if (alux != OP_CMP) regs[dst] <= result;
          done  <= 1'b1;
          state <= S_RETIRE;
        end
        S_RETIRE: begin
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctl.sv
// Bench for alu_issue_ctl: vector table, multi-cycle corner sequences, and a random run
// against a cycle-level reference model. Exercises immediates when ALU_CTL_IMM_EN is defined.
module tb_alu_issue_ctl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        instr_valid, instr_ready;
  logic [3:0]  op;
  logic [2:0]  ra, rb;
  logic [3:0]  alux;
  logic [15:0] arga, argb, result;
  logic        sign, carry, zero, parity;
  logic [3:0]  flags;
  logic        done;
  logic        wr_en;
  logic [2:0]  wr_addr, rd_addr;
  logic [15:0] wr_data, rd_data;
`ifdef ALU_CTL_IMM_EN
  logic        imm_sel;
  logic [15:0] imm;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_issue_ctl #(.NREGS(8), .REG_AW(3)) dut (
    .clk(clk), .resetn(resetn),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .op(op), .ra(ra), .rb(rb),
`ifdef ALU_CTL_IMM_EN
    .imm_sel(imm_sel), .imm(imm),
`endif
    .alux(alux), .arga(arga), .argb(argb),
    .result(result), .sign(sign), .carry(carry), .zero(zero), .parity(parity),
    .flags(flags), .done(done),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  // Stand-in ALU: returns {sign, carry, zero, parity, result}; carry is borrow for SUB/CMP.
  function automatic logic [19:0] alu_f(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] w;
    logic [15:0] r;
    case (o)
      4'h0:       w = {1'b0, b};
      4'h1:       w = {1'b0, a} + {1'b0, b};
      4'h2, 4'hE: w = {1'b0, a} - {1'b0, b};
      4'h3:       w = {1'b0, a & b};
      4'h4:       w = {1'b0, a | b};
      4'h5:       w = {1'b0, a ^ b};
      4'hF:       w = {1'b0, {{8{a[7]}}, a[7:0]}};
      default:    w = {1'b0, a + b + {12'h000, o}};
    endcase
    r = w[15:0];
    return {r[15], w[16], (r == 16'h0000), ^r, r};
  endfunction

  assign {sign, carry, zero, parity, result} = alu_f(alux, arga, argb);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ext_wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [2:0] a, input logic [2:0] b);
    instr_valid = 1'b1; op = o; ra = a; rb = b;
    tick();
    instr_valid = 1'b0;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [2:0]  ra, rb;
    logic [15:0] a, b, exp_r;
    logic [3:0]  exp_f;
  } vec_t;

  vec_t vecs [8];

  logic [15:0] ref_regs [8];
  logic [15:0] nxt_regs [8];
  logic [3:0]  ref_flags, lat_op;
  logic [15:0] lat_a, lat_b;
  logic [2:0]  lat_dst;
  logic [19:0] res;
  logic        exp_done;
  int          phase;

  initial begin
    // flags are {S,C,Z,P}
    vecs[0] = '{4'h1, 3'd1, 3'd2, 16'h0005, 16'h0003, 16'h0008, 4'b0001};
    vecs[1] = '{4'hE, 3'd1, 3'd2, 16'h0004, 16'h0004, 16'h0004, 4'b0010};
    vecs[2] = '{4'h2, 3'd5, 3'd6, 16'h0007, 16'h0002, 16'h0005, 4'b0000};
    vecs[3] = '{4'h2, 3'd5, 3'd6, 16'h0002, 16'h0007, 16'hFFFB, 4'b1101};
    vecs[4] = '{4'h1, 3'd0, 3'd7, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110};
    vecs[5] = '{4'h3, 3'd2, 3'd1, 16'hF0F0, 16'h0FF0, 16'h00F0, 4'b0000};
    vecs[6] = '{4'h0, 3'd3, 3'd3, 16'h8001, 16'h8001, 16'h8001, 4'b1000};
    vecs[7] = '{4'h5, 3'd4, 3'd4, 16'h1234, 16'h1234, 16'h0000, 4'b0010};

    resetn = 1'b0; instr_valid = 1'b0; op = '0; ra = '0; rb = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
`ifdef ALU_CTL_IMM_EN
    imm_sel = 1'b0; imm = '0;
`endif
    #12;
    chk("rst_alux", {28'h0, alux}, 32'h0);
    chk("rst_arga", {16'h0, arga}, 32'h0);
    chk("rst_argb", {16'h0, argb}, 32'h0);
    chk("rst_flags", {28'h0, flags}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    @(negedge clk) resetn = 1'b1;
    tick();
    chk("rst_ready", {31'h0, instr_ready}, 32'h1);
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      #1 chk("rst_reg", {16'h0, rd_data}, 32'h0);
    end

    // vector table
    for (int v = 0; v < 8; v++) begin
      ext_wr(vecs[v].ra, vecs[v].a);
      ext_wr(vecs[v].rb, vecs[v].b);
      chk("vec_ready_idle", {31'h0, instr_ready}, 32'h1);
      rd_addr = vecs[v].ra;
      issue(vecs[v].op, vecs[v].ra, vecs[v].rb);
      chk("vec_alux", {28'h0, alux}, {28'h0, vecs[v].op});
      chk("vec_arga", {16'h0, arga}, {16'h0, vecs[v].a});
      chk("vec_argb", {16'h0, argb}, {16'h0, vecs[v].b});
      chk("vec_ready_exec", {31'h0, instr_ready}, 32'h0);
      chk("vec_done_exec", {31'h0, done}, 32'h0);
      tick();
      chk("vec_done", {31'h0, done}, 32'h1);
      chk("vec_flags", {28'h0, flags}, {28'h0, vecs[v].exp_f});
      chk("vec_result", {16'h0, rd_data}, {16'h0, vecs[v].exp_r});
      tick();
      chk("vec_done_off", {31'h0, done}, 32'h0);
      chk("vec_ready_back", {31'h0, instr_ready}, 32'h1);
    end

    // reset during EXEC: flags currently Z from the last vector
    ext_wr(3'd1, 16'h0007);
    ext_wr(3'd2, 16'h0002);
    issue(4'h2, 3'd1, 3'd2);
    #2 resetn = 1'b0;
    rd_addr = 3'd1;
    #1;
    chk("midrst_reg", {16'h0, rd_data}, 32'h0);
    chk("midrst_flags", {28'h0, flags}, 32'h0);
    chk("midrst_done", {31'h0, done}, 32'h0);
    @(negedge clk) resetn = 1'b1;
    tick();
    chk("midrst_ready", {31'h0, instr_ready}, 32'h1);
    chk("midrst_done2", {31'h0, done}, 32'h0);
    chk("midrst_reg2", {16'h0, rd_data}, 32'h0);

    // writeback wins over a same-edge external write to the same register
    ext_wr(3'd1, 16'h1000);
    ext_wr(3'd2, 16'h0001);
    issue(4'h1, 3'd1, 3'd2);
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_addr = 3'd1;
    #1 chk("wb_wins", {16'h0, rd_data}, 32'h1001);
    tick();
    ext_wr(3'd1, 16'h1000);
    issue(4'h1, 3'd1, 3'd2);
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
    tick();
    wr_en = 1'b0; rd_addr = 3'd3;
    #1 chk("wb_other_ext", {16'h0, rd_data}, 32'hBEEF);
    rd_addr = 3'd1;
    #1 chk("wb_other_res", {16'h0, rd_data}, 32'h1001);
    tick();

    // no bypass: a write on the accept edge is not seen by the operand
    ext_wr(3'd5, 16'h0011);
    ext_wr(3'd6, 16'h0022);
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0999;
    issue(4'h1, 3'd5, 3'd6);
    wr_en = 1'b0;
    chk("nobypass_a", {16'h0, arga}, 32'h0011);
    chk("nobypass_b", {16'h0, argb}, 32'h0022);
    tick();
    rd_addr = 3'd5;
    #1 chk("nobypass_res", {16'h0, rd_data}, 32'h0033);
    tick();

    // continuous valid: one accept every three cycles
    instr_valid = 1'b1; op = 4'h0; ra = 3'd7; rb = 3'd7;
    for (int i = 0; i < 9; i++) begin
      tick();
      chk("stream_ready", {31'h0, instr_ready}, {31'h0, (i % 3 == 2)});
      chk("stream_done", {31'h0, done}, {31'h0, (i % 3 == 1)});
    end
    instr_valid = 1'b0;

`ifdef ALU_CTL_IMM_EN
    ext_wr(3'd1, 16'h00F0);
    ext_wr(3'd2, 16'h5555);
    imm_sel = 1'b1; imm = 16'h000F;
    issue(4'h4, 3'd1, 3'd2);
    imm_sel = 1'b0;
    chk("imm_argb", {16'h0, argb}, 32'h000F);
    tick();
    rd_addr = 3'd1;
    #1 chk("imm_result", {16'h0, rd_data}, 32'h00FF);
    tick();
`endif

    // random run against a reference model, from a fresh reset
    resetn = 1'b0;
    #3;
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 8; i++) ref_regs[i] = '0;
    ref_flags = '0; lat_op = '0; lat_a = '0; lat_b = '0; lat_dst = '0; phase = 0;
    tick();
    for (int c = 0; c < 600; c++) begin
      instr_valid = 1'($urandom_range(0, 1));
      op      = 4'($urandom);
      ra      = 3'($urandom);
      rb      = 3'($urandom);
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom);
      wr_data = 16'($urandom);
      rd_addr = 3'($urandom);
      nxt_regs = ref_regs;
      if (wr_en) nxt_regs[wr_addr] = wr_data;
      exp_done = 1'b0;
      if (phase == 1) begin
        res = alu_f(lat_op, lat_a, lat_b);
        ref_flags = res[19:16];
        if (lat_op != 4'hE) nxt_regs[lat_dst] = res[15:0];
        exp_done = 1'b1;
        phase = 2;
      end else if (phase == 2) begin
        phase = 0;
      end else if (instr_valid) begin
        lat_op = op; lat_a = ref_regs[ra]; lat_b = ref_regs[rb]; lat_dst = ra;
        phase = 1;
      end
      ref_regs = nxt_regs;
      tick();
      chk("rnd_ready", {31'h0, instr_ready}, {31'h0, (phase == 0)});
      chk("rnd_done", {31'h0, done}, {31'h0, exp_done});
      chk("rnd_flags", {28'h0, flags}, {28'h0, ref_flags});
      chk("rnd_rd", {16'h0, rd_data}, {16'h0, ref_regs[rd_addr]});
      chk("rnd_alux", {28'h0, alux}, {28'h0, lat_op});
      chk("rnd_arga", {16'h0, arga}, {16'h0, lat_a});
      chk("rnd_argb", {16'h0, argb}, {16'h0, lat_b});
    end
    instr_valid = 1'b0;
    wr_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
